ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_rr.sv | 39 +++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-requester RAM arbiter.
//   state_t    - arbiter FSM states (IDLE, ISSUE, WAIT)
//   req_idx_t  - requester index (0 or 1)
//   ANCHO_DEF  - default data word width
//   LARGO_DEF  - default RAM depth in words
package ram_arb_pkg;

  localparam int unsigned ANCHO_DEF = 32;
  localparam int unsigned LARGO_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational winner select for the RAM arbiter.
// Configuration macro: RAM_ARB_FIXED_PRIO_EN
//   defined   - requester 0 always wins a tie, last-grant pointer ignored
//   undefined - round-robin: on a tie the requester not granted last wins
// Ports:
//   req0, req1 - requests from requester 0/1
//   last       - index of the requester granted most recently
//   winner     - selected requester (only meaningful when a request is present)
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last,
  output req_idx_t winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = 1'b1;
    if (req0) begin
      winner = 1'b0;
    end
  end
`else
  always_comb begin
    winner = 1'b1;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req0) begin
      winner = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two requesters onto one single-port synchronous RAM
// with one cycle read latency. A write takes two cycles (IDLE, ISSUE), a read
// three (IDLE, ISSUE, WAIT); requests are only sampled in IDLE.
// Configuration macro: RAM_ARB_FIXED_PRIO_EN (fixed priority to requester 0
// instead of round-robin on ties).
// Ports:
//   CLK, RST_n           - clock, asynchronous active-low reset
//   reqN, weN            - request and access type (1 = write) of requester N
//   addrN, wdataN        - word address and write data of requester N
//   gntN                 - one-cycle pulse: command of requester N captured
//   rvalidN, rdataN      - one-cycle read-valid pulse and held read data
//   ram_write_enable     - RAM write strobe
//   ram_read_enable      - RAM read strobe
//   ram_addr, ram_din    - RAM address and write data
//   ram_dout             - RAM read data (valid one cycle after read strobe)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF,
  parameter int unsigned LARGO = LARGO_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(LARGO)-1:0] addr0,
  input  logic [$clog2(LARGO)-1:0] addr1,
  input  logic [ANCHO-1:0]         wdata0,
  input  logic [ANCHO-1:0]         wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [ANCHO-1:0]         rdata0,
  output logic [ANCHO-1:0]         rdata1,
  output logic                     ram_write_enable,
  output logic                     ram_read_enable,
  output logic [$clog2(LARGO)-1:0] ram_addr,
  output logic [ANCHO-1:0]         ram_din,
  input  logic [ANCHO-1:0]         ram_dout
);

  localparam int unsigned AW = $clog2(LARGO);

  state_t          state;
  req_idx_t        owner;
  req_idx_t        last;
  req_idx_t        winner;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [ANCHO-1:0] wdata_q;
  logic            issue;

  ram_arb_rr u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (winner)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= winner;
            last    <= winner;
            we_q    <= winner ? we1    : we0;
            addr_q  <= winner ? addr1  : addr0;
            wdata_q <= winner ? wdata1 : wdata0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= we_q ? IDLE : WAIT;
        end
        WAIT: begin
          // RAM output is valid now; capture it for the owner only so the
          // other requester's rdata keeps its last value.
          state <= IDLE;
          if (owner) begin
            rdata1  <= ram_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_dout;
            rvalid0 <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant and RAM strobes are decoded from the registered ISSUE state, so they
  // drop to zero together with the asynchronous reset.
  assign issue            = (state == ISSUE);
  assign gnt0             = issue && !owner;
  assign gnt1             = issue &&  owner;
  assign ram_write_enable = issue &&  we_q;
  assign ram_read_enable  = issue && !we_q;
  assign ram_addr         = issue ? addr_q  : '0;
  assign ram_din          = issue ? wdata_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural
// one-cycle-latency RAM, directed table, hand sequences and a randomized
// run against a transaction-level timing/round-robin model.
module tb_ram_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 10;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0]  rdata0, rdata1;
  logic          ram_write_enable, ram_read_enable;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din, ram_dout;

  int n_cmp = 0;
  int n_bad = 0;
  bit inv_on = 1'b0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.ANCHO(W), .LARGO(D)) dut (
    .CLK              (CLK),
    .RST_n            (RST_n),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .rvalid0          (rvalid0),
    .rvalid1          (rvalid1),
    .rdata0           (rdata0),
    .rdata1           (rdata1),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_addr         (ram_addr),
    .ram_din          (ram_din),
    .ram_dout         (ram_dout)
  );

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] v;
    v = 32'hC0DE0000 ^ (32'(a) * 32'h9E3779B1);
    if (a == 16) v = 32'h1234;
    if (a == 17) v = 32'h5678;
    return v;
  endfunction

  // Synchronous RAM, one cycle read latency.
  logic [W-1:0] mem [0:D-1];
  logic [W-1:0] shadow [0:D-1];
  initial begin
    for (int i = 0; i < int'(D); i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    ram_dout = '0;
  end
  always @(posedge CLK) begin
    if (ram_write_enable) mem[ram_addr] <= ram_din;
    if (ram_read_enable)  ram_dout      <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Protocol invariants checked every cycle.
  always @(negedge CLK) begin
    if (inv_on && RST_n) begin
      chk("gnt_excl",    {31'd0, gnt0 & gnt1}, 32'd0);
      chk("rvalid_excl", {31'd0, rvalid0 & rvalid1}, 32'd0);
      chk("ram_ctl_with_gnt",
          {30'd0, ram_write_enable | ram_read_enable, ram_write_enable & ram_read_enable},
          {30'd0, gnt0 | gnt1, 1'b0});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Observation of a window of cycles: grants and read returns with cycle stamps.
  int          gq_w[$], gq_c[$], rq_w[$], rq_c[$];
  logic [31:0] rq_d[$];

  task automatic watch(input int ncyc, input bit auto_drop, input int max_g);
    int ng;
    ng = 0;
    gq_w.delete(); gq_c.delete(); rq_w.delete(); rq_c.delete(); rq_d.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge CLK);
      if (gnt0 || gnt1) begin
        gq_w.push_back(gnt1 ? 1 : 0);
        gq_c.push_back(i);
        ng++;
        if (auto_drop) begin
          if (gnt0) req0 = 1'b0;
          if (gnt1) req1 = 1'b0;
        end
        if (ng >= max_g) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (rvalid0) begin rq_w.push_back(0); rq_c.push_back(i); rq_d.push_back(rdata0); end
      if (rvalid1) begin rq_w.push_back(1); rq_c.push_back(i); rq_d.push_back(rdata1); end
    end
  endtask

  task automatic chk_g(input string nm, input int idx, input int w, input int cyc);
    if (idx < gq_w.size()) begin
      chk({nm, "_gnt_who"}, gq_w[idx], w);
      chk({nm, "_gnt_cyc"}, gq_c[idx], cyc);
    end else begin
      chk({nm, "_gnt_missing"}, gq_w.size(), idx + 1);
    end
  endtask

  task automatic chk_r(input string nm, input int idx, input int w, input int cyc, input logic [31:0] d);
    if (idx < rq_w.size()) begin
      chk({nm, "_rv_who"},  rq_w[idx], w);
      chk({nm, "_rv_cyc"},  rq_c[idx], cyc);
      chk({nm, "_rv_data"}, rq_d[idx], d);
    end else begin
      chk({nm, "_rv_missing"}, rq_w.size(), idx + 1);
    end
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (gnt0 || gnt1) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [31:0]   d0, d1;
    int            win;
    logic [31:0]   rd;
  } vec_t;

  localparam int NT = 9;
  vec_t tbl [NT];

  // Random-phase model state.
  int          c, free_at, g_cyc, rv_cyc, last_m, g_own, w, lat, nrv, rvc, rvw;
  bit          g_we, ew;
  logic [AW-1:0] g_addr;
  logic [31:0] g_wdata, rv_data, rvd;
  bit          pend [2];
  bit          cw [2];
  logic [AW-1:0] ca [2];
  logic [31:0] cd [2];
  logic [31:0] exp_rd [2];

  initial begin
    //            r0    r1    w0    w1    a0      a1       d0            d1            win rd
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd13, 10'd0,   32'hA234,     32'h0,        0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd13, 10'd0,   32'h0,        32'h0,        0, 32'hA234};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd0,  10'd20,  32'h0,        32'hBEEF,     1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd0,  10'd13,  32'h0,        32'h0,        1, 32'hA234};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd5,  10'd5,   32'h11,       32'h22,       0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd5,  10'd5,   32'h0,        32'h0,        1, 32'h11};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  10'd0,   32'hFFFFFFFF, 32'h0,        0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0,  10'd0,   32'h0,        32'h0,        0, 32'hFFFFFFFF};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd0,  10'd1023, 32'h0,       32'h0,        1, init_word(1023)};
`ifdef RAM_ARB_FIXED_PRIO_EN
    tbl[5].win = 0;
`endif

    RST_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst_gnt",    {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_ramctl", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    chk("rst_ramaddr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ramdin", ram_din, 32'd0);
    RST_n = 1'b1;
    inv_on = 1'b1;

    // Both read from reset: requester 0 wins the first tie.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd16;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd17;
    watch(8, 1'b1, 2);
    chk("tie_rd_ngnt", gq_w.size(), 2);
    chk_g("tie_rd0", 0, 0, 1);
    chk_g("tie_rd1", 1, 1, 4);
    chk("tie_rd_nrv", rq_w.size(), 2);
    chk_r("tie_rd0", 0, 0, 3, 32'h1234);
    chk_r("tie_rd1", 1, 1, 6, 32'h5678);

    // Directed table of single transactions from an idle arbiter.
    for (int i = 0; i < NT; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      wait_gnt(lat);
      chk($sformatf("tbl%0d_gnt_lat", i), lat, 1);
      if (lat != 0) chk($sformatf("tbl%0d_winner", i), {31'd0, gnt1}, tbl[i].win);
      ew = (tbl[i].win == 1) ? tbl[i].w1 : tbl[i].w0;
      req0 = 1'b0; req1 = 1'b0;
      nrv = 0; rvc = 0; rvw = 0; rvd = '0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge CLK);
        if (rvalid0 || rvalid1) begin
          nrv++; rvc = k; rvw = rvalid1 ? 1 : 0; rvd = rvalid1 ? rdata1 : rdata0;
        end
      end
      if (ew) begin
        chk($sformatf("tbl%0d_no_rvalid_on_write", i), nrv, 0);
      end else begin
        chk($sformatf("tbl%0d_nrvalid", i), nrv, 1);
        chk($sformatf("tbl%0d_rv_cyc", i), rvc, 2);
        chk($sformatf("tbl%0d_rv_who", i), rvw, tbl[i].win);
        chk($sformatf("tbl%0d_rdata", i), rvd, tbl[i].rd);
      end
    end

    // Both hold write requests for six accesses.
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd30; wdata0 = 32'h3030;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd31; wdata1 = 32'h3131;
    watch(14, 1'b0, 6);
    chk("alt_ngnt", gq_w.size(), 6);
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk_g($sformatf("alt%0d", i), i, 0, 1 + 2 * i);
`else
      chk_g($sformatf("alt%0d", i), i, i % 2, 1 + 2 * i);
`endif
    end
    chk("alt_nrv", rq_w.size(), 0);

    // Back-to-back: requester 1 writes, requester 0 reads the same word.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd20; wdata1 = 32'hDEAD;
    wait_gnt(lat);
    chk("b2b_wr_lat", lat, 1);
    chk("b2b_wr_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd20;
    watch(6, 1'b1, 1);
    chk("b2b_ngnt", gq_w.size(), 1);
    chk_g("b2b_rd", 0, 0, 2);
    chk("b2b_nrv", rq_w.size(), 1);
    chk_r("b2b_rd", 0, 0, 4, 32'hDEAD);

    // Reset pulse during WAIT of a read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd13;
    @(negedge CLK);
    chk("rstw_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("rstw_gnt",    {30'd0, gnt0, gnt1}, 32'd0);
    chk("rstw_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    chk("rstw_rdata0", rdata0, 32'd0);
    chk("rstw_rdata1", rdata1, 32'd0);
    chk("rstw_ramctl", {30'd0, ram_write_enable, ram_read_enable}, 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    watch(5, 1'b1, 1);
    chk("rstw_quiet_gnt", gq_w.size(), 0);
    chk("rstw_quiet_rv",  rq_w.size(), 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd13;
    watch(5, 1'b1, 1);
    chk("rstw_after_ngnt", gq_w.size(), 1);
    chk_g("rstw_after", 0, 0, 1);
    chk_r("rstw_after", 0, 0, 3, 32'hA234);

    // Randomized traffic against a transaction-level model.
    RST_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    c = 0; free_at = 1; g_cyc = -1; rv_cyc = -1; last_m = 1; g_own = 0;
    g_we = 1'b0; g_addr = '0; g_wdata = '0; rv_data = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int k = 0; k < 1500; k++) begin
      if (c == rv_cyc) exp_rd[g_own] = rv_data;
      chk("rnd_gnt0",    {31'd0, gnt0},    {31'd0, (c == g_cyc && g_own == 0)});
      chk("rnd_gnt1",    {31'd0, gnt1},    {31'd0, (c == g_cyc && g_own == 1)});
      chk("rnd_rvalid0", {31'd0, rvalid0}, {31'd0, (c == rv_cyc && g_own == 0)});
      chk("rnd_rvalid1", {31'd0, rvalid1}, {31'd0, (c == rv_cyc && g_own == 1)});
      chk("rnd_rdata0", rdata0, exp_rd[0]);
      chk("rnd_rdata1", rdata1, exp_rd[1]);
      if (c == g_cyc) begin
        chk("rnd_ram_we",   {31'd0, ram_write_enable}, {31'd0, g_we});
        chk("rnd_ram_addr", {22'd0, ram_addr}, {22'd0, g_addr});
        if (g_we) chk("rnd_ram_din", ram_din, g_wdata);
      end
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && c == g_cyc && g_own == r) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          cw[r]   = 1'($urandom_range(0, 1));
          ca[r]   = AW'(64 + $urandom_range(0, 31));
          cd[r]   = $urandom;
        end
      end
      req0 = pend[0]; we0 = cw[0]; addr0 = ca[0]; wdata0 = cd[0];
      req1 = pend[1]; we1 = cw[1]; addr1 = ca[1]; wdata1 = cd[1];
      if (c + 1 >= free_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = (last_m == 0) ? 1 : 0;
`endif
        end else begin
          w = pend[0] ? 0 : 1;
        end
        g_own = w; g_cyc = c + 1; g_we = cw[w]; g_addr = ca[w]; g_wdata = cd[w];
        if (g_we) begin
          shadow[g_addr] = g_wdata;
          rv_cyc  = -1;
          free_at = c + 3;
        end else begin
          rv_data = shadow[g_addr];
          rv_cyc  = c + 3;
          free_at = c + 4;
        end
        last_m = w;
      end
      @(negedge CLK);
      c++;
    end

    req0 = 1'b0; req1 = 1'b0;
    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
